// File: rtl/operand_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : operand_mux_arbiter
// Description : Arbitrates two operand producers onto a shared 2:1 operand
//               mux path. Each requester gets a valid/ready handshake. The
//               winning operand is registered into a single output slot.
//               The slot also exports the registered mux select and one
//               saturating grant counter per source.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Build option:
//   MUX_ARB_RR_EN  defined   -> round-robin grant when both requesters are valid
//                  undefined -> fixed priority, in0 over in1
// ----------------------------------------------------------------------------
// Ports:
//   clk         in   1            rising-edge clock
//   rst         in   1            asynchronous, active-high reset
//   in0_valid   in   1            requester 0 has an operand
//   in0_data    in   DATA_W       requester 0 operand
//   in0_ready   out  1            requester 0 operand accepted this cycle
//   in1_valid   in   1            requester 1 has an operand
//   in1_data    in   DATA_W       requester 1 operand
//   in1_ready   out  1            requester 1 operand accepted this cycle
//   out_valid   out  1            output slot holds an operand
//   out_data    out  DATA_W       registered operand
//   out_ready   in   1            consumer takes the operand this cycle
//   mux_sel     out  1            source of out_data (0 = in0, 1 = in1)
//   grant_cnt0  out  GRANT_CNT_W  saturating count of in0 transfers
//   grant_cnt1  out  GRANT_CNT_W  saturating count of in1 transfers
// ============================================================================
module operand_mux_arbiter #(
    parameter int DATA_W      = 16,
    parameter int GRANT_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in0_valid,
    input  logic [DATA_W-1:0]      in0_data,
    output logic                   in0_ready,
    input  logic                   in1_valid,
    input  logic [DATA_W-1:0]      in1_data,
    output logic                   in1_ready,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    input  logic                   out_ready,
    output logic                   mux_sel,
    output logic [GRANT_CNT_W-1:0] grant_cnt0,
    output logic [GRANT_CNT_W-1:0] grant_cnt1
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    localparam logic [GRANT_CNT_W-1:0] c_CNT_MAX = '1;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [DATA_W-1:0]        r_data;
    logic                     r_sel;
    logic [GRANT_CNT_W-1:0]   r_cnt0;
    logic [GRANT_CNT_W-1:0]   r_cnt1;

    logic                     w_can_accept;
    logic                     w_grant;      // 0 = in0, 1 = in1
    logic                     w_accept;

    // The slot can take a new operand when empty, or when the current one
    // leaves this same cycle (drain and refill with no bubble).
    assign w_can_accept = (r_state == ST_EMPTY) || out_ready;

`ifdef MUX_ARB_RR_EN
    logic r_rr_ptr;

    // Contention goes to the pointer; a lone requester always wins.
    assign w_grant = (in0_valid && in1_valid) ? r_rr_ptr : in1_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_accept) begin
            r_rr_ptr <= ~w_grant;
        end
    end
`else
    // Fixed priority: in1 only when in0 is idle.
    assign w_grant = ~in0_valid;
`endif

    assign in0_ready = w_can_accept && !w_grant && in0_valid;
    assign in1_ready = w_can_accept &&  w_grant && in1_valid;
    assign w_accept  = in0_ready || in1_ready;

    // ------------------------------------------------------------------
    // Slot state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (out_ready && !w_accept) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operand slot and select
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_sel  <= 1'b0;
        end else if (w_accept) begin
            r_data <= w_grant ? in1_data : in0_data;
            r_sel  <= w_grant;
        end
    end

    // ------------------------------------------------------------------
    // Saturating grant counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (in0_ready && (r_cnt0 != c_CNT_MAX)) begin
                r_cnt0 <= r_cnt0 + GRANT_CNT_W'(1);
            end
            if (in1_ready && (r_cnt1 != c_CNT_MAX)) begin
                r_cnt1 <= r_cnt1 + GRANT_CNT_W'(1);
            end
        end
    end

    assign out_valid  = (r_state == ST_FULL);
    assign out_data   = r_data;
    assign mux_sel    = r_sel;
    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;

endmodule
`default_nettype wire

// File: tb/tb_operand_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_operand_mux_arbiter
// Description : Directed self-checking bench for operand_mux_arbiter with a
//               scoreboard queue of expected operands and a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_operand_mux_arbiter;

    localparam int DW = 16;
    localparam int CW = 4;
    localparam int c_CMAX = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in0_valid = 1'b0;
    logic [DW-1:0] in0_data  = '0;
    logic          in0_ready;
    logic          in1_valid = 1'b0;
    logic [DW-1:0] in1_data  = '0;
    logic          in1_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 1'b0;
    logic          mux_sel;
    logic [CW-1:0] grant_cnt0;
    logic [CW-1:0] grant_cnt1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          s;
    } item_t;
    item_t sbq[$];

    // Reference model state
    logic m_full = 1'b0;
    logic m_rr   = 1'b0;
    int   m_cnt0 = 0;
    int   m_cnt1 = 0;

    operand_mux_arbiter #(.DATA_W(DW), .GRANT_CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .in0_valid  (in0_valid),
        .in0_data   (in0_data),
        .in0_ready  (in0_ready),
        .in1_valid  (in1_valid),
        .in1_data   (in1_data),
        .in1_ready  (in1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .mux_sel    (mux_sel),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model grant: 1 selects in1
    function automatic logic m_grant();
`ifdef MUX_ARB_RR_EN
        if (in0_valid && in1_valid) return m_rr;
        return in1_valid;
`else
        return !in0_valid;
`endif
    endfunction

    function automatic logic m_r0();
        return (!m_full || out_ready) && !m_grant() && in0_valid;
    endfunction

    function automatic logic m_r1();
        return (!m_full || out_ready) && m_grant() && in1_valid;
    endfunction

    // Model update and scoreboard push on every predicted accept
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_full = 1'b0;
            m_rr   = 1'b0;
            m_cnt0 = 0;
            m_cnt1 = 0;
            sbq.delete();
        end else begin
            logic a0, a1;
            a0 = m_r0();
            a1 = m_r1();
            if (a0 || a1) begin
                sbq.push_back('{d: (a1 ? in1_data : in0_data), s: a1});
                m_rr = ~a1;
                m_full = 1'b1;
            end else if (out_ready) begin
                m_full = 1'b0;
            end
            if (a0 && m_cnt0 < c_CMAX) m_cnt0++;
            if (a1 && m_cnt1 < c_CMAX) m_cnt1++;
        end
    end

    // Monitor: compare handshake/counters each cycle, pop on consumption
    always @(negedge clk) begin
        if (!rst) begin
            chk("in0_ready", in0_ready, m_r0());
            chk("in1_ready", in1_ready, m_r1());
            chk("out_valid", out_valid, m_full);
            chk("grant_cnt0", grant_cnt0, m_cnt0);
            chk("grant_cnt1", grant_cnt1, m_cnt1);
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    item_t it;
                    it = sbq.pop_front();
                    chk("sb_out_data", out_data, it.d);
                    chk("sb_mux_sel", mux_sel, it.s);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [DW-1:0] d0,
                         input logic v1, input logic [DW-1:0] d1, input logic ordy);
        in0_valid = v0;
        in0_data  = d0;
        in1_valid = v1;
        in1_data  = d1;
        out_ready = ordy;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        cyc();
    endtask

    task automatic drain();
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        repeat (3) cyc();
    endtask

    initial begin
        logic exp_sel;
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_mux_sel", mux_sel, 0);
        chk("rst_cnt0", grant_cnt0, 0);
        chk("rst_cnt1", grant_cnt1, 0);
        rst = 1'b0;
        cyc();

        // 1: single in0 transfer
        drive(1'b1, 16'h1234, 1'b0, '0, 1'b1);
        #1;
        chk("t1_in0_ready", in0_ready, 1);
        cyc();
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_data", out_data, 16'h1234);
        chk("t1_mux_sel", mux_sel, 0);
        chk("t1_cnt0", grant_cnt0, 1);
        drain();

        // 2/3: both valid for 4 cycles
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'hAAAA, 1'b1, 16'h5555, 1'b1);
            cyc();
`ifdef MUX_ARB_RR_EN
            exp_sel = (i % 2 == 1);
`else
            exp_sel = 1'b0;
`endif
            chk("t2_mux_sel", mux_sel, exp_sel);
            chk("t2_out_data", out_data, exp_sel ? 16'h5555 : 16'hAAAA);
        end
        drive(1'b0, '0, 1'b0, '0, 1'b1);
        #1;
`ifdef MUX_ARB_RR_EN
        chk("t2_cnt0", grant_cnt0, 2);
        chk("t2_cnt1", grant_cnt1, 2);
`else
        chk("t3_cnt0", grant_cnt0, 4);
        chk("t3_cnt1", grant_cnt1, 0);
`endif
        drain();

        // 4: backpressure then drain+accept in one cycle
        do_reset();
        drive(1'b1, 16'h1111, 1'b0, '0, 1'b1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, '0, 1'b1, 16'hBEEF, 1'b0);
            #1;
            chk("t4_hold_data", out_data, 16'h1111);
            chk("t4_hold_r0", in0_ready, 0);
            chk("t4_hold_r1", in1_ready, 0);
            cyc();
        end
        out_ready = 1'b1;
        #1;
        chk("t4_r1", in1_ready, 1);
        cyc();
        chk("t4_out_valid", out_valid, 1);
        chk("t4_out_data", out_data, 16'hBEEF);
        chk("t4_mux_sel", mux_sel, 1);
        drain();

        // 5: counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, DW'(i), 1'b0, '0, 1'b1);
            cyc();
        end
        chk("t5_cnt0_sat", grant_cnt0, 15);
        drain();
        chk("t5_cnt0_hold", grant_cnt0, 15);

        // 6: asynchronous reset while FULL
        do_reset();
        drive(1'b1, 16'h4321, 1'b0, '0, 1'b0);
        cyc();
        drive(1'b0, '0, 1'b0, '0, 1'b0);
        chk("t6_full", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", out_valid, 0);
        chk("t6_async_cnt0", grant_cnt0, 0);
        chk("t6_async_data", out_data, 0);
        rst = 1'b0;
        cyc();
        drive(1'b0, '0, 1'b1, 16'h7777, 1'b1);
        cyc();
        chk("t6_out_data", out_data, 16'h7777);
        chk("t6_mux_sel", mux_sel, 1);
        chk("t6_cnt1", grant_cnt1, 1);
        drain();

        chk("end_sb_empty", sbq.size(), 0);
        chk("end_out_valid", out_valid, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
